// File: rtl/io_window_decoder.sv
// I/O cycle decoder: NUM_WIN base/mask windows with per-window wait states, routed to slot chip selects.
// Optional feature macro IO_TIMEOUT_EN adds a STRETCH timeout that releases READY and pulses bus_err.

module io_window_regs #(
    parameter int ADDR_W    = 8,
    parameter int NUM_WIN   = 4,
    parameter int NUM_SLOTS = 5,
    parameter int WS_W      = 4,
    parameter int WIN_W     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_we,
    input  logic [WIN_W+2:0]                 cfg_addr,
    input  logic [ADDR_W-1:0]                cfg_wdata,
    output logic [NUM_WIN-1:0][ADDR_W-1:0]   base,
    output logic [NUM_WIN-1:0][ADDR_W-1:0]   mask,
    output logic [NUM_WIN-1:0][2:0]          slot,
    output logic [NUM_WIN-1:0][1:0]          op,
    output logic [NUM_WIN-1:0][WS_W-1:0]     ws
);
    logic [2:0]       field;
    logic [WIN_W-1:0] win;

    assign field = cfg_addr[WIN_W+2:WIN_W];
    assign win   = cfg_addr[WIN_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base <= '0;
            mask <= '1;
            slot <= '0;
            op   <= '0;
            ws   <= '0;
        end else if (cfg_we) begin
            case (field)
                3'd0: base[win] <= cfg_wdata;
                3'd1: mask[win] <= cfg_wdata;
                // slot numbers beyond the populated slots are dropped
                3'd2: if ({1'b0, cfg_wdata[2:0]} < 4'(NUM_SLOTS)) slot[win] <= cfg_wdata[2:0];
                3'd3: op[win] <= cfg_wdata[1:0];
                3'd4: ws[win] <= cfg_wdata[WS_W-1:0];
                default: ;
            endcase
        end
    end
endmodule

// state     | meaning
// S_IDLE    | no cycle; capture decode when iorq_n falls
// S_WAIT    | fixed wait states, ready_n held low, cnt counts down
// S_STRETCH | ready_n follows the selected slot's dev_ready_n
// S_HOLD    | ready released; hold frozen decode until iorq_n rises
module io_window_decoder #(
    parameter int ADDR_W    = 8,
    parameter int NUM_WIN   = 4,
    parameter int NUM_SLOTS = 5,
    parameter int WS_W      = 4,
    parameter int TO_CYC    = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        iorq_n,
    input  logic                        r_w_,
    input  logic [NUM_SLOTS-1:0]        dev_ready_n,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_WIN)+2:0]  cfg_addr,
    input  logic [ADDR_W-1:0]           cfg_wdata,
    output logic                        ready_n,
    output logic                        data_oe_n,
    output logic                        data_dir,
    output logic                        ff_oe_n,
    output logic                        win_valid,
    output logic [$clog2(NUM_WIN)-1:0]  win_index,
    output logic [2:0]                  sel_slot,
    output logic [NUM_SLOTS-1:0]        cs_n,
    output logic                        bus_err
);
    localparam int WIN_W = $clog2(NUM_WIN);

    if (NUM_WIN < 2 || NUM_WIN > 16 || NUM_SLOTS < 2 || NUM_SLOTS > 8 || TO_CYC < 1) begin : g_param_check
        $error("io_window_decoder: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STRETCH, S_HOLD} state_t;

    state_t                           state_q, state_d;
    logic [NUM_WIN-1:0][ADDR_W-1:0]   base, mask;
    logic [NUM_WIN-1:0][2:0]          slot;
    logic [NUM_WIN-1:0][1:0]          op;
    logic [NUM_WIN-1:0][WS_W-1:0]     ws;

    logic             hit;
    logic [WIN_W-1:0] hit_idx;
    logic [2:0]       hit_slot;
    logic [WS_W-1:0]  hit_ws;
    logic             cap_en;
    logic             cap_valid_q, cap_rw_q;
    logic [WIN_W-1:0] cap_idx_q;
    logic [2:0]       cap_slot_q;
    logic [WS_W-1:0]  cnt_q, cnt_d;
    logic             slot_ready_n;
    logic             to_expire, timed_out;

    io_window_regs #(
        .ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .NUM_SLOTS(NUM_SLOTS), .WS_W(WS_W), .WIN_W(WIN_W)
    ) u_regs (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .base(base), .mask(mask), .slot(slot), .op(op), .ws(ws)
    );

    // descending scan so the lowest matching window is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if ((((addr ^ base[i]) & mask[i]) == '0) && (r_w_ ? op[i][0] : op[i][1])) begin
                hit     = 1'b1;
                hit_idx = WIN_W'(i);
            end
        end
    end

    assign hit_slot = hit ? slot[hit_idx] : 3'd0;
    assign hit_ws   = ws[hit_idx];

    always_comb begin
        slot_ready_n = 1'b1;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (cap_slot_q == 3'(s)) slot_ready_n = dev_ready_n[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_rw_q    <= 1'b0;
            cap_idx_q   <= '0;
            cap_slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap_en) begin
                cap_valid_q <= hit;
                cap_rw_q    <= r_w_;
                cap_idx_q   <= hit_idx;
                cap_slot_q  <= hit_slot;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!iorq_n) begin
                    cap_en = 1'b1;
                    if (!hit) begin
                        state_d = S_HOLD;
                    end else if (hit_ws != '0) begin
                        state_d = S_WAIT;
                        cnt_d   = hit_ws;
                    end else begin
                        state_d = S_STRETCH;
                    end
                end
            end
            S_WAIT: begin
                if (iorq_n)                     state_d = S_IDLE;
                else if (cnt_q == WS_W'(1))     state_d = S_STRETCH;
                else                            cnt_d   = cnt_q - WS_W'(1);
            end
            S_STRETCH: begin
                if (iorq_n)                         state_d = S_IDLE;
                else if (slot_ready_n || to_expire) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (iorq_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef IO_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timed_out_q;

    assign to_expire = (state_q == S_STRETCH) && !iorq_n && !slot_ready_n && (to_cnt_q == TO_W'(1));
    assign timed_out = timed_out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (state_d != S_STRETCH)      to_cnt_q <= '0;
            else if (state_q != S_STRETCH) to_cnt_q <= TO_W'(TO_CYC);
            else                           to_cnt_q <= to_cnt_q - TO_W'(1);
            if (cap_en)         timed_out_q <= 1'b0;
            else if (to_expire) timed_out_q <= 1'b1;
        end
    end
`else
    assign to_expire = 1'b0;
    assign timed_out = 1'b0;
`endif

    assign bus_err = to_expire;

    always_comb begin
        cs_n      = '1;
        ready_n   = 1'b1;
        data_oe_n = 1'b1;
        data_dir  = 1'b0;
        ff_oe_n   = 1'b1;
        win_valid = 1'b0;
        win_index = '0;
        sel_slot  = '0;
        if (state_q != S_IDLE) begin
            win_valid = cap_valid_q;
            win_index = cap_idx_q;
            sel_slot  = cap_slot_q;
            data_dir  = cap_rw_q;
            if (cap_valid_q && !timed_out) begin
                data_oe_n = 1'b0;
                for (int s = 0; s < NUM_SLOTS; s++) cs_n[s] = (cap_slot_q != 3'(s));
            end else begin
                // unclaimed or abandoned read: the CPU sees 0xFF
                ff_oe_n = !cap_rw_q;
            end
            if (state_q == S_WAIT)         ready_n = 1'b0;
            else if (state_q == S_STRETCH) ready_n = slot_ready_n;
        end
    end
endmodule

// File: tb/tb_io_window_decoder.sv
// Self-checking bench for io_window_decoder: directed cycles plus randomized traffic against a
// transaction-level reference model of the window table and cycle timeline.
module tb_io_window_decoder;
    localparam int ADDR_W    = 8;
    localparam int NUM_WIN   = 4;
    localparam int NUM_SLOTS = 5;
    localparam int WS_W      = 4;
    localparam int TO_CYC    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic       iorq_n;
    logic       r_w_;
    logic [4:0] dev_ready_n;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       ready_n, data_oe_n, data_dir, ff_oe_n, win_valid, bus_err;
    logic [1:0] win_index;
    logic [2:0] sel_slot;
    logic [4:0] cs_n;

    always #5 clk = ~clk;

    io_window_decoder #(
        .ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .NUM_SLOTS(NUM_SLOTS), .WS_W(WS_W), .TO_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
        .dev_ready_n(dev_ready_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .ready_n(ready_n), .data_oe_n(data_oe_n), .data_dir(data_dir), .ff_oe_n(ff_oe_n),
        .win_valid(win_valid), .win_index(win_index), .sel_slot(sel_slot), .cs_n(cs_n),
        .bus_err(bus_err)
    );

    logic [7:0] m_base [NUM_WIN];
    logic [7:0] m_mask [NUM_WIN];
    logic [2:0] m_slot [NUM_WIN];
    logic [1:0] m_op   [NUM_WIN];
    logic [3:0] m_ws   [NUM_WIN];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string ctx, input logic e_rdy, input logic e_oe, input logic e_dir,
                           input logic e_ff, input logic e_valid, input int e_idx, input int e_slot,
                           input logic [4:0] e_cs, input logic e_berr);
        chk({ctx, "/ready_n"},   32'(ready_n),   32'(e_rdy));
        chk({ctx, "/data_oe_n"}, 32'(data_oe_n), 32'(e_oe));
        chk({ctx, "/data_dir"},  32'(data_dir),  32'(e_dir));
        chk({ctx, "/ff_oe_n"},   32'(ff_oe_n),   32'(e_ff));
        chk({ctx, "/win_valid"}, 32'(win_valid), 32'(e_valid));
        chk({ctx, "/win_index"}, 32'(win_index), 32'(e_idx));
        chk({ctx, "/sel_slot"},  32'(sel_slot),  32'(e_slot));
        chk({ctx, "/cs_n"},      32'(cs_n),      32'(e_cs));
        chk({ctx, "/bus_err"},   32'(bus_err),   32'(e_berr));
    endtask

    task automatic expect_idle(input string ctx);
        chk_all(ctx, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 5'h1f, 1'b0);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_WIN; i++) begin
            m_base[i] = 8'h00; m_mask[i] = 8'hff; m_slot[i] = 3'd0; m_op[i] = 2'd0; m_ws[i] = 4'd0;
        end
    endfunction

    function automatic void model_cfg(input int field, input int win, input logic [7:0] d);
        case (field)
            0: m_base[win] = d;
            1: m_mask[win] = d;
            2: if (int'(d[2:0]) < NUM_SLOTS) m_slot[win] = d[2:0];
            3: m_op[win] = d[1:0];
            4: m_ws[win] = d[3:0];
            default: ;
        endcase
    endfunction

    function automatic void predict(input logic [7:0] a, input logic rw, output logic hit,
                                    output int idx, output int slot, output int ws);
        hit = 1'b0; idx = 0; slot = 0; ws = 0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (!hit && (((a ^ m_base[i]) & m_mask[i]) == 8'h00) && (rw ? m_op[i][0] : m_op[i][1])) begin
                hit = 1'b1; idx = i; slot = int'(m_slot[i]); ws = int'(m_ws[i]);
            end
        end
    endfunction

    task automatic cfg_write(input int field, input int win, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = {3'(field), 2'(win)}; cfg_wdata = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        model_cfg(field, win, d);
    endtask

    // One CPU cycle: busy = STRETCH clocks the slot stays busy, hold = extra HOLD clocks,
    // abort_at > 0 raises iorq_n early, mid_at > 0 issues a config write during the cycle.
    task automatic run_io(input string name, input logic [7:0] a, input logic rw, input int busy,
                          input int hold, input int abort_at, input int mid_at, input int mid_field,
                          input int mid_win, input logic [7:0] mid_data);
        logic hit, timed, e_rdy, e_berr, in_hold, e_sel;
        int idx, slot, ws, slen, full, last, j;
        logic [4:0] e_cs;
        predict(a, rw, hit, idx, slot, ws);
        timed = 1'b0;
        slen  = busy + 1;
`ifdef IO_TIMEOUT_EN
        if (busy >= TO_CYC) begin slen = TO_CYC; timed = 1'b1; end
`endif
        full = hit ? ws + slen + hold + 1 : hold + 1;
        last = (abort_at > 0 && abort_at < full) ? abort_at : full;
        @(negedge clk);
        addr = a; r_w_ = rw; iorq_n = 1'b0; dev_ready_n = 5'($urandom);
        #1 expect_idle({name, "/cap"});
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            addr = 8'($urandom); r_w_ = 1'($urandom);
            dev_ready_n = 5'($urandom);
            if (hit) dev_ready_n[slot] = (k <= ws + busy) ? 1'b0 : 1'b1;
            cfg_we = 1'b0;
            if (k == mid_at) begin
                cfg_we = 1'b1; cfg_addr = {3'(mid_field), 2'(mid_win)}; cfg_wdata = mid_data;
                model_cfg(mid_field, mid_win, mid_data);
            end
            iorq_n = (k == last);
            in_hold = !hit || (k > ws + slen);
            e_rdy = 1'b1; e_berr = 1'b0;
            if (hit && k <= ws) begin
                e_rdy = 1'b0;
            end else if (!in_hold) begin
                j = k - ws - 1;
                e_rdy  = (j < busy) ? 1'b0 : 1'b1;
                e_berr = timed && (j == slen - 1) && (k != last);
            end
            e_sel = hit && !(timed && in_hold);
            e_cs  = e_sel ? ~(5'b00001 << slot) : 5'h1f;
            #1 chk_all($sformatf("%s/k%0d", name, k), e_rdy, !e_sel, rw, !(rw && !e_sel),
                       hit, idx, slot, e_cs, e_berr);
        end
        @(negedge clk);
        cfg_we = 1'b0; dev_ready_n = 5'($urandom);
        #1 expect_idle({name, "/end"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a;
        int w;
        rst_n = 1'b0; iorq_n = 1'b1; addr = 8'h00; r_w_ = 1'b1; dev_ready_n = '1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        #1 expect_idle("reset");
        rst_n = 1'b1;

        cfg_write(0, 0, 8'h10); cfg_write(1, 0, 8'hff); cfg_write(2, 0, 8'h00);
        cfg_write(3, 0, 8'h03); cfg_write(4, 0, 8'h00);
        run_io("t1_write_ws0", 8'h10, 1'b0, 0, 1, 0, 0, 0, 0, 8'h00);

        cfg_write(0, 1, 8'h30); cfg_write(1, 1, 8'hf0); cfg_write(2, 1, 8'h01);
        cfg_write(3, 1, 8'h01); cfg_write(4, 1, 8'h02);
        run_io("t2_read_ws2", 8'h31, 1'b1, 0, 2, 0, 0, 0, 0, 8'h00);
        run_io("t3_stretch5", 8'h31, 1'b1, 5, 1, 0, 0, 0, 0, 8'h00);
        run_io("t4_write_ro", 8'h32, 1'b0, 0, 1, 0, 0, 0, 0, 8'h00);
        run_io("t4_read_unmapped", 8'h77, 1'b1, 0, 1, 0, 0, 0, 0, 8'h00);

        cfg_write(0, 2, 8'h10); cfg_write(1, 2, 8'hff); cfg_write(2, 2, 8'h03);
        cfg_write(3, 2, 8'h03); cfg_write(4, 2, 8'h01);
        run_io("t5_lowest_wins", 8'h10, 1'b1, 1, 1, 0, 2, 3, 0, 8'h00);
        run_io("t5_after_disable", 8'h10, 1'b1, 0, 1, 0, 0, 0, 0, 8'h00);
        cfg_write(2, 2, 8'h07);
        cfg_write(5, 2, 8'haa);
        run_io("t5_ignored_writes", 8'h10, 1'b0, 2, 0, 0, 0, 0, 0, 8'h00);
        run_io("abort_wait", 8'h31, 1'b1, 3, 0, 1, 0, 0, 0, 8'h00);
        run_io("abort_stretch", 8'h31, 1'b1, 4, 0, 4, 0, 0, 0, 8'h00);
`ifdef IO_TIMEOUT_EN
        run_io("t6_timeout_read", 8'h31, 1'b1, 12, 1, 0, 0, 0, 0, 8'h00);
        cfg_write(3, 1, 8'h03);
        run_io("t6_timeout_write", 8'h31, 1'b0, 20, 0, 0, 0, 0, 0, 8'h00);
`endif

        cfg_write(0, 3, 8'h80); cfg_write(1, 3, 8'hf0); cfg_write(2, 3, 8'h04);
        cfg_write(3, 3, 8'h03); cfg_write(4, 3, 8'h06);
        @(negedge clk);
        addr = 8'h85; r_w_ = 1'b1; iorq_n = 1'b0; dev_ready_n = '1;
        @(negedge clk);
        #1 chk("rst_wait/ready_n", 32'(ready_n), 32'(0));
        chk("rst_wait/cs_n", 32'(cs_n), 32'(5'b01111));
        chk("rst_wait/win_index", 32'(win_index), 32'(3));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1 expect_idle("rst_wait/after_reset");
        iorq_n = 1'b1; rst_n = 1'b1;
        model_reset();
        run_io("rst_cfg_cleared", 8'h85, 1'b1, 0, 0, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < NUM_WIN; i++) begin
            cfg_write(0, i, 8'($urandom));
            cfg_write(1, i, 8'($urandom) | 8'hc0);
            cfg_write(2, i, 8'($urandom_range(4, 0)));
            cfg_write(3, i, 8'($urandom_range(3, 1)));
            cfg_write(4, i, 8'($urandom_range(3, 0)));
        end
        for (int it = 0; it < 60; it++) begin
            int ncfg;
            ncfg = $urandom_range(2, 0);
            for (int c = 0; c < ncfg; c++)
                cfg_write($urandom_range(7, 0), $urandom_range(NUM_WIN - 1, 0), 8'($urandom));
            w = $urandom_range(NUM_WIN - 1, 0);
            if ($urandom_range(3, 0) != 0) a = (m_base[w] & m_mask[w]) | (8'($urandom) & ~m_mask[w]);
            else a = 8'($urandom);
`ifdef IO_TIMEOUT_EN
            run_io($sformatf("rnd%0d", it), a, 1'($urandom), $urandom_range(10, 0), $urandom_range(2, 0),
                   ($urandom_range(3, 0) == 0) ? $urandom_range(6, 1) : 0,
                   ($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0,
                   $urandom_range(7, 0), $urandom_range(NUM_WIN - 1, 0), 8'($urandom));
`else
            run_io($sformatf("rnd%0d", it), a, 1'($urandom), $urandom_range(4, 0), $urandom_range(2, 0),
                   ($urandom_range(3, 0) == 0) ? $urandom_range(6, 1) : 0,
                   ($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0,
                   $urandom_range(7, 0), $urandom_range(NUM_WIN - 1, 0), 8'($urandom));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
